// File: rtl/coeff_token_ctrl.sv
// CAVLC coeff_token sequencer: owns a 32-bit MSB-first bitstream window, drives the
// external coeff_token ROM bank and decodes the 6-bit FLC table internally for nC >= 8.
module coeff_token_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bits_in,
    input  logic        bits_valid,
    output logic        bits_ready,
    input  logic        start,
    input  logic [4:0]  nc,
    input  logic        chroma_dc,
    output logic [15:0] rom_addr,
    output logic [1:0]  rom_sel,
    input  logic [4:0]  rom_total_coeff,
    input  logic [1:0]  rom_trailing_ones,
    input  logic [4:0]  rom_num_shift,
    output logic [4:0]  total_coeff,
    output logic [1:0]  trailing_ones,
    output logic        done,
    output logic        busy,
    output logic        error
);

    typedef enum logic [2:0] {StIdle, StWait, StLookup, StApply, StErr} state_e;

    state_e      state_q, state_d;
    logic [31:0] window_q, window_d;
    logic [5:0]  bit_count_q, bit_count_d;
    logic [1:0]  rom_sel_q;
    logic        flc_q;
    logic [4:0]  res_tc_q;
    logic [1:0]  res_t1_q;
    logic [4:0]  shift_q;
    logic [4:0]  tc_q;
    logic [1:0]  t1_q;
    logic        done_q;
    logic        error_q;

    logic        accept;
    logic        consume;
    logic [5:0]  count_after;
    logic [31:0] window_after;
    logic [1:0]  sel_new;
    logic        flc_new;
    logic [4:0]  lk_tc;
    logic [1:0]  lk_t1;
    logic [4:0]  lk_shift;
    logic        shift_bad;

    // Window update: consume first, then a new word lands right after the remaining bits.
    always_comb begin
        accept       = bits_valid & bits_ready;
        consume      = (state_q == StApply);
        count_after  = bit_count_q;
        window_after = window_q;
        if (consume) begin
            count_after  = bit_count_q - {1'b0, shift_q};
            window_after = window_q << shift_q;
        end
        window_d    = window_after;
        bit_count_d = count_after;
        if (accept) begin
            window_d    = window_after | ({bits_in, 16'h0000} >> count_after);
            bit_count_d = count_after + 6'd16;
        end
    end

    always_comb begin
        if (chroma_dc)       sel_new = 2'd3;
        else if (nc < 5'd2)  sel_new = 2'd0;
        else if (nc < 5'd4)  sel_new = 2'd1;
        else                 sel_new = 2'd2;
        flc_new = (nc >= 5'd8) & ~chroma_dc;
    end

    // Result selection for the LOOKUP cycle; 6'b000011 is the FLC escape for zero coeffs.
    always_comb begin
        lk_tc     = rom_total_coeff;
        lk_t1     = rom_trailing_ones;
        lk_shift  = rom_num_shift;
        shift_bad = (rom_num_shift == 5'd0) | (rom_num_shift > 5'd16);
        if (flc_q) begin
            lk_shift  = 5'd6;
            shift_bad = 1'b0;
            if (window_q[31:26] == 6'b000011) begin
                lk_tc = 5'd0;
                lk_t1 = 2'd0;
            end else begin
                lk_tc = {1'b0, window_q[31:28]} + 5'd1;
                lk_t1 = window_q[27:26];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (start) state_d = (bit_count_q >= 6'd16) ? StLookup : StWait;
            end
            StWait:   if (bit_count_d >= 6'd16) state_d = StLookup;
            StLookup: state_d = shift_bad ? StErr : StApply;
            StApply:  state_d = StIdle;
            StErr:    state_d = StErr;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        busy          = (state_q != StIdle);
        bits_ready    = (bit_count_q <= 6'd16) & ~error_q;
        rom_addr      = window_q[31:16];
        rom_sel       = rom_sel_q;
        total_coeff   = tc_q;
        trailing_ones = t1_q;
        done          = done_q;
        error         = error_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            window_q    <= 32'h0;
            bit_count_q <= 6'd0;
            rom_sel_q   <= 2'd0;
            flc_q       <= 1'b0;
            res_tc_q    <= 5'd0;
            res_t1_q    <= 2'd0;
            shift_q     <= 5'd0;
            tc_q        <= 5'd0;
            t1_q        <= 2'd0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            window_q    <= window_d;
            bit_count_q <= bit_count_d;
            done_q      <= (state_q == StApply);
            if (state_q == StIdle && start) begin
                rom_sel_q <= sel_new;
                flc_q     <= flc_new;
            end
            if (state_q == StLookup) begin
                res_tc_q <= lk_tc;
                res_t1_q <= lk_t1;
                shift_q  <= lk_shift;
                if (shift_bad) error_q <= 1'b1;
            end
            if (state_q == StApply) begin
                tc_q <= res_tc_q;
                t1_q <= res_t1_q;
            end
        end
    end

endmodule

// File: tb/tb_coeff_token_ctrl.sv
// Directed bench for coeff_token_ctrl with a small behavioural coeff_token ROM model.
module tb_coeff_token_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] bits_in = 16'h0;
    logic        bits_valid = 1'b0;
    logic        bits_ready;
    logic        start = 1'b0;
    logic [4:0]  nc = 5'd0;
    logic        chroma_dc = 1'b0;
    logic [15:0] rom_addr;
    logic [1:0]  rom_sel;
    logic [4:0]  rom_tc;
    logic [1:0]  rom_t1;
    logic [4:0]  rom_ns;
    logic [4:0]  total_coeff;
    logic [1:0]  trailing_ones;
    logic        done;
    logic        busy;
    logic        error;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    coeff_token_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .bits_in           (bits_in),
        .bits_valid        (bits_valid),
        .bits_ready        (bits_ready),
        .start             (start),
        .nc                (nc),
        .chroma_dc         (chroma_dc),
        .rom_addr          (rom_addr),
        .rom_sel           (rom_sel),
        .rom_total_coeff   (rom_tc),
        .rom_trailing_ones (rom_t1),
        .rom_num_shift     (rom_ns),
        .total_coeff       (total_coeff),
        .trailing_ones     (trailing_ones),
        .done              (done),
        .busy              (busy),
        .error             (error)
    );

    // Partial coeff_token tables; unmatched codes return shift 0 (invalid).
    always_comb begin
        {rom_tc, rom_t1, rom_ns} = {5'd0, 2'd0, 5'd0};
        case (rom_sel)
            2'd0: casez (rom_addr)
                16'b1???_????_????_????: {rom_tc, rom_t1, rom_ns} = {5'd0, 2'd0, 5'd1};
                16'b01??_????_????_????: {rom_tc, rom_t1, rom_ns} = {5'd1, 2'd1, 5'd2};
                16'b001?_????_????_????: {rom_tc, rom_t1, rom_ns} = {5'd2, 2'd2, 5'd3};
                16'b0001_1???_????_????: {rom_tc, rom_t1, rom_ns} = {5'd3, 2'd3, 5'd5};
                16'b0000_0000_0000_0001: {rom_tc, rom_t1, rom_ns} = {5'd13, 2'd1, 5'd16};
                default: ;
            endcase
            2'd1: if (rom_addr[15:14] == 2'b11) {rom_tc, rom_t1, rom_ns} = {5'd0, 2'd0, 5'd2};
            2'd2: if (rom_addr[15:12] == 4'hf) {rom_tc, rom_t1, rom_ns} = {5'd0, 2'd0, 5'd17};
            default: if (rom_addr[15]) {rom_tc, rom_t1, rom_ns} = {5'd1, 2'd1, 5'd1};
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] w);
        bits_in    = w;
        bits_valid = 1'b1;
        tick();
        bits_valid = 1'b0;
    endtask

    task automatic do_reset();
        start      = 1'b0;
        bits_valid = 1'b0;
        chroma_dc  = 1'b0;
        rst_n      = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        // Reset state
        tick();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_tc", total_coeff, 0);
        chk("rst_t1", trailing_ones, 0);
        chk("rst_romsel", rom_sel, 0);
        chk("rst_ready", bits_ready, 1);
        chk("rst_addr", rom_addr, 0);
        rst_n = 1'b1;
        tick();

        // nC=0, code "01" -> TC=1, T1=1, shift 2
        nc = 5'd0;
        push(16'h5400);
        chk("t1_addr0", rom_addr, 16'h5400);
        chk("t1_ready16", bits_ready, 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_busy", busy, 1);
        chk("t1_romsel", rom_sel, 0);
        chk("t1_nodone0", done, 0);
        tick();
        chk("t1_nodone1", done, 0);
        tick();
        chk("t1_done", done, 1);
        chk("t1_tc", total_coeff, 1);
        chk("t1_t1", trailing_ones, 1);
        chk("t1_idle", busy, 0);
        chk("t1_addr", rom_addr, 16'h5000);
        chk("t1_cnt", dut.bit_count_q, 14);
        tick();
        chk("t1_pulse", done, 0);
        chk("t1_hold", total_coeff, 1);

        // Back-to-back starts: second start waits for a word
        do_reset();
        push(16'h8000);
        start = 1'b1;
        tick();
        tick();
        tick();
        chk("t2_done", done, 1);
        chk("t2_tc", total_coeff, 0);
        chk("t2_t1", trailing_ones, 0);
        chk("t2_cnt", dut.bit_count_q, 15);
        chk("t2_ready", bits_ready, 1);
        tick();
        start = 1'b0;
        chk("t2_wait_busy", busy, 1);
        chk("t2_wait_nodone", done, 0);
        tick();
        tick();
        chk("t2_still_wait", busy, 1);
        push(16'hffff);
        chk("t2_lk_addr", rom_addr, 16'h0001);
        chk("t2_lk_nodone", done, 0);
        tick();
        chk("t2_ap_nodone", done, 0);
        tick();
        chk("t2_done2", done, 1);
        chk("t2_tc2", total_coeff, 13);
        chk("t2_t12", trailing_ones, 1);
        chk("t2_addr2", rom_addr, 16'hfffe);
        chk("t2_cnt2", dut.bit_count_q, 15);
        tick();
        tick();
        chk("t2_noqueue_busy", busy, 0);
        chk("t2_noqueue_done", done, 0);

        // FLC path nC=9: 000011 then 010110, then a ROM code of length 5
        do_reset();
        nc = 5'd9;
        push(16'h0d61);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t3_done", done, 1);
        chk("t3_tc", total_coeff, 0);
        chk("t3_t1", trailing_ones, 0);
        chk("t3_addr", rom_addr, 16'h5840);
        chk("t3_cnt", dut.bit_count_q, 10);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t3_wait", busy, 1);
        push(16'hc000);
        tick();
        tick();
        chk("t3_done2", done, 1);
        chk("t3_tc2", total_coeff, 6);
        chk("t3_t12", trailing_ones, 2);
        chk("t3_cnt2", dut.bit_count_q, 20);
        chk("t3_ready20", bits_ready, 0);
        chk("t3_addr2", rom_addr, 16'h1c00);
        nc = 5'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t3_done3", done, 1);
        chk("t3_tc3", total_coeff, 3);
        chk("t3_t13", trailing_ones, 3);
        chk("t3_cnt3", dut.bit_count_q, 15);
        chk("t3_ready15", bits_ready, 1);
        chk("t3_addr3", rom_addr, 16'h8000);

        // Word accepted during APPLY with shift 3
        do_reset();
        nc = 5'd0;
        push(16'h3fff);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        bits_in    = 16'h8001;
        bits_valid = 1'b1;
        tick();
        bits_valid = 1'b0;
        chk("t4_done", done, 1);
        chk("t4_tc", total_coeff, 2);
        chk("t4_t1", trailing_ones, 2);
        chk("t4_cnt", dut.bit_count_q, 29);
        chk("t4_window", dut.window_q, 32'hfffc0008);
        chk("t4_ready", bits_ready, 0);
        chk("t4_addr", rom_addr, 16'hfffc);
        chroma_dc = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_sel_cdc", rom_sel, 3);
        tick();
        tick();
        chk("t4_cdc_done", done, 1);
        chk("t4_cdc_tc", total_coeff, 1);
        chk("t4_cdc_t1", trailing_ones, 1);
        chk("t4_cdc_addr", rom_addr, 16'hfff8);
        chroma_dc = 1'b0;
        nc = 5'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t4_sel_nc2", rom_sel, 1);
        tick();
        tick();
        chk("t4_nc2_done", done, 1);
        chk("t4_nc2_tc", total_coeff, 0);
        chk("t4_nc2_addr", rom_addr, 16'hffe0);
        chk("t4_nc2_cnt", dut.bit_count_q, 26);

        // Invalid ROM shift (17) -> sticky error
        do_reset();
        nc = 5'd5;
        push(16'hffff);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_sel", rom_sel, 2);
        tick();
        chk("t5_error", error, 1);
        chk("t5_busy", busy, 1);
        chk("t5_ready", bits_ready, 0);
        start      = 1'b1;
        bits_in    = 16'h1234;
        bits_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t5_nodone", done, 0);
        end
        chk("t5_stuck_busy", busy, 1);
        chk("t5_stuck_err", error, 1);
        chk("t5_noaccept", dut.bit_count_q, 16);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_err", error, 0);
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_ready", bits_ready, 1);
        chk("t5_rst_sel", rom_sel, 0);
        chk("t5_rst_addr", rom_addr, 0);
        start      = 1'b0;
        bits_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Reset during LOOKUP drops the request and buffered bits
        nc = 5'd0;
        push(16'h5400);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t6_pre_tc", total_coeff, 1);
        push(16'h5400);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_lookup_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_busy", busy, 0);
        chk("t6_cnt", dut.bit_count_q, 0);
        chk("t6_tc", total_coeff, 0);
        chk("t6_t1", trailing_ones, 0);
        chk("t6_addr", rom_addr, 0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("t6_nodone", done, 0);
        end
        chk("t6_idle", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
